// File: rtl/mm_bram_parallel_ctrl_if.sv
// Bus bundle between the parallel BRAM row controller and its host/datapath.
// The cycle_count member exists only when MM_CTRL_PERF_CNT_EN is defined.
interface mm_bram_parallel_ctrl_if #(
    parameter int ROW_ADDR_WIDTH = 5
);
    logic                      start;
    logic                      stall;
    logic                      busy;
    logic                      done;
    logic                      src_rd_en;
    logic [ROW_ADDR_WIDTH-1:0] src_rdaddr;
    logic                      dpath_sum_en;
    logic [ROW_ADDR_WIDTH-1:0] dpath_result_wraddr;
    logic                      row_wr_en_in;
`ifdef MM_CTRL_PERF_CNT_EN
    logic [31:0]               cycle_count;

    modport master (
        input  start, stall, row_wr_en_in,
        output busy, done, src_rd_en, src_rdaddr,
               dpath_sum_en, dpath_result_wraddr, cycle_count
    );
    modport slave (
        output start, stall, row_wr_en_in,
        input  busy, done, src_rd_en, src_rdaddr,
               dpath_sum_en, dpath_result_wraddr, cycle_count
    );
`else
    modport master (
        input  start, stall, row_wr_en_in,
        output busy, done, src_rd_en, src_rdaddr,
               dpath_sum_en, dpath_result_wraddr
    );
    modport slave (
        output start, stall, row_wr_en_in,
        input  busy, done, src_rd_en, src_rdaddr,
               dpath_sum_en, dpath_result_wraddr
    );
`endif
endinterface

// File: rtl/mm_bram_parallel_ctrl.sv
// Issues ROW_NUM source row reads, aligns valid/address with the SRAM latency and
// waits for every row result to return. Optional job cycle counter: MM_CTRL_PERF_CNT_EN.
module mm_bram_parallel_ctrl #(
    parameter int  ROW_NUM        = 32,
    parameter int  SRC_RD_LATENCY = 1,
    localparam int ROW_ADDR_WIDTH = $clog2(ROW_NUM)
) (
    input  logic                    clk,
    input  logic                    reset,
    mm_bram_parallel_ctrl_if.master bus
);
    localparam int                        RET_W     = ROW_ADDR_WIDTH + 1;
    localparam logic [ROW_ADDR_WIDTH-1:0] LAST_ADDR = ROW_ADDR_WIDTH'(ROW_NUM - 1);
    localparam logic [ROW_ADDR_WIDTH-1:0] ADDR_ONE  = ROW_ADDR_WIDTH'(1);
    localparam logic [RET_W-1:0]          ROW_TOTAL = RET_W'(ROW_NUM);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t                    r_state;
    state_t                    w_next_state;
    logic [ROW_ADDR_WIDTH-1:0] r_issue_cnt;
    logic [RET_W-1:0]          r_ret_cnt;
    logic [RET_W-1:0]          w_ret_next;
    logic                      w_counting;
    logic                      w_accept;
    logic                      w_rd_en;
    logic [ROW_ADDR_WIDTH-1:0] w_rd_addr;
    logic [SRC_RD_LATENCY-1:0] r_vld_dl;
    logic [ROW_ADDR_WIDTH-1:0] r_addr_dl [SRC_RD_LATENCY];

    assign w_accept   = (r_state == IDLE) && bus.start;
    assign w_counting = (r_state == ISSUE) || (r_state == DRAIN);
    assign w_ret_next = r_ret_cnt + {{ROW_ADDR_WIDTH{1'b0}}, w_counting & bus.row_wr_en_in};
    assign w_rd_addr  = w_rd_en ? r_issue_cnt : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_rd_en      = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (bus.start) w_next_state = ISSUE;
            end
            ISSUE: begin
                if (!bus.stall) begin
                    w_rd_en = 1'b1;
                    if (r_issue_cnt == LAST_ADDR) w_next_state = DRAIN;
                end
            end
            DRAIN: begin
                if (w_ret_next >= ROW_TOTAL) w_next_state = DONE;
            end
            DONE: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // The issue counter parks on the last address so it never wraps or runs past ROW_NUM-1.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_issue_cnt <= '0;
            r_ret_cnt   <= '0;
        end else if (w_accept) begin
            r_issue_cnt <= '0;
            r_ret_cnt   <= '0;
        end else begin
            if (w_rd_en && (r_issue_cnt != LAST_ADDR)) r_issue_cnt <= r_issue_cnt + ADDR_ONE;
            r_ret_cnt <= w_ret_next;
        end
    end

    // Valid/address delay line models the SRAM read latency and ignores stall.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_vld_dl <= '0;
            for (int i = 0; i < SRC_RD_LATENCY; i++) r_addr_dl[i] <= '0;
        end else begin
            r_vld_dl[0]  <= w_rd_en;
            r_addr_dl[0] <= w_rd_addr;
            for (int i = 1; i < SRC_RD_LATENCY; i++) begin
                r_vld_dl[i]  <= r_vld_dl[i-1];
                r_addr_dl[i] <= r_addr_dl[i-1];
            end
        end
    end

`ifdef MM_CTRL_PERF_CNT_EN
    logic [31:0] r_cycle_cnt;

    // Counts ISSUE and DRAIN cycles; the value freezes in DONE and through IDLE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cycle_cnt <= '0;
        end else if (w_accept) begin
            r_cycle_cnt <= '0;
        end else if (w_counting && (r_cycle_cnt != 32'hFFFF_FFFF)) begin
            r_cycle_cnt <= r_cycle_cnt + 32'd1;
        end
    end

    assign bus.cycle_count = r_cycle_cnt;
`endif

    assign bus.busy                = (r_state != IDLE);
    assign bus.done                = (r_state == DONE);
    assign bus.src_rd_en           = w_rd_en;
    assign bus.src_rdaddr          = w_rd_addr;
    assign bus.dpath_sum_en        = r_vld_dl[SRC_RD_LATENCY-1];
    assign bus.dpath_result_wraddr = r_addr_dl[SRC_RD_LATENCY-1];
endmodule
